// File: rtl/cvtws_seq_if.sv
// Shared constants and the operand/result handshake bundle for the
// binary32 -> int32 sequential converter.
package cvtws_pkg;
  localparam int INTN    = 32;
  localparam int NEXP    = 8;
  localparam int NSIG    = 23;
  localparam int BIAS    = 127;
  localparam int NRAS    = 5;
  localparam int LAST_RA = NRAS - 1;

  // One-hot rounding attribute bit positions.
  localparam int RA_RNE = 0;  // roundTiesToEven
  localparam int RA_RTZ = 1;  // roundTowardZero
  localparam int RA_RTP = 2;  // roundTowardPositive
  localparam int RA_RTN = 3;  // roundTowardNegative
  localparam int RA_RNA = 4;  // roundTiesToAway
endpackage

interface cvtws_seq_if;
  import cvtws_pkg::*;

  logic [NEXP+NSIG:0] s;
  logic [LAST_RA:0]   ra;
  logic               in_valid;
  logic               in_ready;
  logic [INTN-1:0]    w;
  logic               out_valid;
  logic               out_ready;
  logic               inexact;
  logic               invalid;

  modport master (
    output s, ra, in_valid, out_ready,
    input  in_ready, w, out_valid, inexact, invalid
  );

  modport slave (
    input  s, ra, in_valid, out_ready,
    output in_ready, w, out_valid, inexact, invalid
  );
endinterface

// File: rtl/cvtws_seq.sv
// Sequential binary32 -> signed 32-bit integer converter (MIPS cvt.w.s).
// Shifts one significand bit per cycle, then rounds and range-checks once.
module cvtws_seq
  import cvtws_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  cvtws_seq_if.slave  io_bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t           r_state;
  logic             r_sign;
  logic [LAST_RA:0] r_ra;
  logic [INTN-1:0]  r_int;
  logic             r_guard;
  logic             r_sticky;
  logic [4:0]       r_count;
  logic             r_left;
  logic             r_bad;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [INTN-1:0]  r_w;
  logic             r_inexact;
  logic             r_invalid;

  logic [NEXP-1:0]  w_exp;
  logic [NSIG:0]    w_sig;
  logic [INTN-1:0]  w_int;
  logic             w_sticky;
  logic             w_bad;
  logic             w_left;
  logic [4:0]       w_n;

  // Operand classification, used only on the acceptance edge.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_exp    = io_bus.s[NEXP+NSIG-1:NSIG];
    w_sig    = {(w_exp != '0), io_bus.s[NSIG-1:0]};
    w_int    = {{(INTN-NSIG-1){1'b0}}, w_sig};
    w_sticky = 1'b0;
    w_bad    = 1'b0;
    w_left   = 1'b0;
    w_n      = '0;
    if (w_exp == '1) begin
      w_bad = 1'b1;
    end else if (io_bus.s == 32'hCF00_0000) begin
      w_int = 32'h8000_0000;
    end else if (w_exp >= 8'd158) begin
      w_bad = 1'b1;
    end else if (w_exp <= 8'd125) begin
      w_int    = '0;
      w_sticky = |io_bus.s[NEXP+NSIG-1:0];
    end else if (w_exp >= 8'd150) begin
      w_left = 1'b1;
      w_n    = 5'(w_exp - 8'd150);
    end else begin
      w_n    = 5'(8'd150 - w_exp);
    end
  end

  logic             w_lost;
  logic             w_inc;
  logic [INTN:0]    w_mag;
  logic             w_ovf;
  logic [INTN-1:0]  w_res;

  // Rounding increment, post-round range check and sign application.
  always_comb begin
    w_lost = r_guard | r_sticky;
    w_inc  = ~r_ra[RA_RTZ] & (
               (r_ra[RA_RNE] & r_guard & (r_sticky | r_int[0])) |
               (r_ra[RA_RTP] & ~r_sign & w_lost) |
               (r_ra[RA_RTN] &  r_sign & w_lost) |
               (r_ra[RA_RNA] & r_guard));
    w_mag  = {1'b0, r_int} + {{INTN{1'b0}}, w_inc};
    w_ovf  = r_sign ? (w_mag > 33'h0_8000_0000) : (w_mag > 33'h0_7FFF_FFFF);
    w_res  = r_sign ? (~w_mag[INTN-1:0] + {{(INTN-1){1'b0}}, 1'b1}) : w_mag[INTN-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_ra        <= '0;
      r_int       <= '0;
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
      r_count     <= '0;
      r_left      <= 1'b0;
      r_bad       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_w         <= '0;
      r_inexact   <= 1'b0;
      r_invalid   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (io_bus.in_valid) begin
            r_sign     <= io_bus.s[NEXP+NSIG];
            r_ra       <= io_bus.ra;
            r_int      <= w_int;
            r_guard    <= 1'b0;
            r_sticky   <= w_sticky;
            r_count    <= w_n;
            r_left     <= w_left;
            r_bad      <= w_bad;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_count == '0) begin
            r_state <= ROUND;
          end else begin
            r_count <= r_count - 5'd1;
            if (r_left) begin
              r_int <= r_int << 1;
            end else begin
              {r_int, r_guard} <= {1'b0, r_int};
              r_sticky         <= r_sticky | r_guard;
            end
          end
        end
        ROUND: begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
          // MIPS default result for any invalid conversion, whatever the sign.
          if (r_bad || w_ovf) begin
            r_w       <= 32'h7FFF_FFFF;
            r_invalid <= 1'b1;
            r_inexact <= 1'b0;
          end else begin
            r_w       <= w_res;
            r_invalid <= 1'b0;
            r_inexact <= w_lost;
          end
        end
        DONE: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.w         = r_w;
  assign io_bus.inexact   = r_inexact;
  assign io_bus.invalid   = r_invalid;

endmodule
